// File: rtl/twiddle_gen_q.sv
// twiddle_gen_q: FFT twiddle-factor generator.
// Produces cos(2*pi*k/N) and sin(2*pi*k/N) as signed Q1.(W-1) words from a
// quarter-wave sine table that is built at elaboration and folded by quadrant.
// Requests come either from single lookups (req_*) or from an internal
// sweep sequencer that issues k = 0, s, 2s, ... (mod N) for one FFT stage.
// All requests go through a two-stage registered valid/ready pipeline.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   single-lookup handshake, req_k = twiddle index
//   sweep_start       one-cycle pulse starting a sweep (stride, count latched)
//   sweep_stride      index increment per sweep step, mod N
//   sweep_count       number of indices issued by the sweep, 0..N
//   sweep_busy        high from sweep acceptance until its last word is taken
//   out_valid/ready   output handshake
//   out_cos, out_sin  twiddle components, signed Q1.(W-1)
//   out_k             index that produced the word
//   out_last          final word of a sweep (0 for single lookups)
module twiddle_gen_q #(
    parameter int W     = 16,
    parameter int N     = 16,
    parameter int LOG2N = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LOG2N-1:0]        req_k,
    input  logic                    sweep_start,
    input  logic [LOG2N-1:0]        sweep_stride,
    input  logic [LOG2N:0]          sweep_count,
    output logic                    sweep_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W-1:0]     out_cos,
    output logic signed [W-1:0]     out_sin,
    output logic [LOG2N-1:0]        out_k,
    output logic                    out_last
);

    localparam int     QW    = LOG2N - 1;            // table index width (0..N/4)
    localparam int     RW    = LOG2N - 2;            // offset within a quadrant
    localparam longint PI_FX = 64'sd3373259426;      // pi * 2^30

    // round(2^(W-1) * sin(2*pi*i/N)) for i in 0..N/4, saturated to 2^(W-1)-1.
    // Fixed-point Taylor series at 2^30 scale; argument never exceeds pi/2,
    // so the result is non-negative and adding one half rounds away from zero.
    function automatic logic signed [W-1:0] qval(input int idx);
        longint x, x2, term, acc, scaled, lim;
        x    = (longint'(2) * PI_FX * longint'(idx)) / longint'(N);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) acc = acc - term;
            else            acc = acc + term;
        end
        if (acc < 0) acc = 0;
        scaled = ((acc <<< (W - 1)) + (longint'(1) <<< 29)) >>> 30;
        lim    = (longint'(1) <<< (W - 1)) - 1;
        if (scaled > lim) scaled = lim;
        return scaled[W-1:0];
    endfunction

    logic signed [W-1:0] qtab [0:N/4];

    for (genvar g = 0; g <= N / 4; g++) begin : g_tab
        localparam logic signed [W-1:0] QV = qval(g);
        assign qtab[g] = QV;
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
    state_t state, state_nx;

    logic             advance;
    logic             issue;
    logic             issue_last;
    logic [LOG2N-1:0] issue_k;

    logic [LOG2N-1:0] sw_k;
    logic [LOG2N-1:0] sw_stride;
    logic [LOG2N:0]   sw_cnt;

    logic             s1_valid;
    logic [1:0]       s1_q;
    logic [RW-1:0]    s1_r;
    logic [LOG2N-1:0] s1_k;
    logic             s1_last;

    logic [QW-1:0]       idx_a, idx_b;
    logic signed [W-1:0] qa, qb, fold_cos, fold_sin;

    assign advance = !out_valid || out_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sweep_start && sweep_count != '0) state_nx = SWEEP;
            SWEEP:   if (advance && sw_cnt == (LOG2N+1)'(1)) state_nx = DRAIN;
            // the final sweep word is the last thing in the pipeline
            DRAIN:   if (out_valid && out_ready && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: request arbitration and the issue port into stage 1
    always_comb begin
        req_ready  = 1'b0;
        issue      = 1'b0;
        issue_k    = '0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                req_ready = advance && !sweep_start;
                issue     = req_valid && req_ready;
                issue_k   = req_k;
            end
            SWEEP: begin
                issue      = advance;
                issue_k    = sw_k;
                issue_last = (sw_cnt == (LOG2N+1)'(1));
            end
            default: ;
        endcase
    end

    assign sweep_busy = (state != IDLE);

    // sweep address sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_k      <= '0;
            sw_stride <= '0;
            sw_cnt    <= '0;
        end else if (state == IDLE && sweep_start && sweep_count != '0) begin
            sw_k      <= '0;
            sw_stride <= sweep_stride;
            sw_cnt    <= sweep_count;
        end else if (state == SWEEP && advance) begin
            sw_k   <= sw_k + sw_stride;
            sw_cnt <= sw_cnt - (LOG2N+1)'(1);
        end
    end

    // quadrant fold; negation cannot overflow since no entry is -2^(W-1)
    always_comb begin
        idx_a = QW'(s1_r);
        idx_b = QW'(N / 4) - idx_a;
        qa    = qtab[idx_a];
        qb    = qtab[idx_b];
        case (s1_q)
            2'd0:    begin fold_cos =  qb; fold_sin =  qa; end
            2'd1:    begin fold_cos = -qa; fold_sin =  qb; end
            2'd2:    begin fold_cos = -qb; fold_sin = -qa; end
            default: begin fold_cos =  qa; fold_sin = -qb; end
        endcase
    end

    // two-stage pipeline, both stages held while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s1_r      <= '0;
            s1_k      <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_sin   <= '0;
            out_k     <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            s1_valid <= issue;
            if (issue) begin
                s1_q    <= issue_k[LOG2N-1:LOG2N-2];
                s1_r    <= issue_k[RW-1:0];
                s1_k    <= issue_k;
                s1_last <= issue_last;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_cos  <= fold_cos;
                out_sin  <= fold_sin;
                out_k    <= s1_k;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen_q.sv
// Testbench for twiddle_gen_q (N=16, W=16): table-driven single lookups,
// exhaustive sweep of k, sequencer sweeps, backpressure, arbitration and
// mid-sweep reset, checked through an in-order scoreboard.
module tb_twiddle_gen_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_k;
    logic        sweep_start;
    logic [3:0]  sweep_stride;
    logic [4:0]  sweep_count;
    logic        sweep_busy;
    logic        out_valid;
    logic        out_ready;
    logic signed [15:0] out_cos;
    logic signed [15:0] out_sin;
    logic [3:0]  out_k;
    logic        out_last;

    twiddle_gen_q #(.W(16), .N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
        .sweep_start(sweep_start), .sweep_stride(sweep_stride), .sweep_count(sweep_count),
        .sweep_busy(sweep_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin), .out_k(out_k), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] k;
        int         cosv;
        int         sinv;
        logic       last;
        bit         exact;
        bit         chk_lat;
        int         acc_cyc;
    } exp_t;

    typedef struct {
        logic [3:0] k;
        int         c;
        int         s;
    } vec_t;

    exp_t sb[$];
    vec_t vt[5];

    // expectation for requests accepted from req_* (set by the driver)
    int nxt_c, nxt_s;
    bit mode_tol = 0;
    bit mode_lat = 0;
    int mon_pops = 0;
    int first_pop = 0;
    int last_pop  = 0;

    localparam real PI = 3.14159265358979323846;

    function automatic real ref_real(int k, bit is_sin);
        real a;
        a = 2.0 * PI * real'(k) / 16.0;
        return 32768.0 * (is_sin ? $sin(a) : $cos(a));
    endfunction

    function automatic int ref_round(int k, bit is_sin);
        real v;
        int  r;
        v = ref_real(k, is_sin);
        if (v >= 0.0) r = int'($floor(v + 0.5));
        else          r = -int'($floor(-v + 0.5));
        if (r > 32767)  r = 32767;
        if (r < -32767) r = -32767;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input real r);
        real d;
        checks++;
        d = real'(act) - r;
        if (d < 0.0) d = -d;
        if (d > 1.0) begin
            failures++;
            $display("FAIL %s: got %0d expected %f +/-1 (t=%0t)", name, act, r, $time);
        end
    endtask

    // scoreboard: push on request acceptance, pop and compare on output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (req_valid && req_ready) begin
                e.k       = req_k;
                e.cosv    = nxt_c;
                e.sinv    = nxt_s;
                e.last    = 1'b0;
                e.exact   = !mode_tol;
                e.chk_lat = mode_lat;
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word_k", longint'(out_k), -1);
                end else begin
                    e = sb.pop_front();
                    chk("out_k", longint'(out_k), longint'(e.k));
                    chk("out_last", longint'(out_last), longint'(e.last));
                    if (e.exact) begin
                        chk("out_cos", longint'(out_cos), longint'(e.cosv));
                        chk("out_sin", longint'(out_sin), longint'(e.sinv));
                    end else begin
                        chk_tol("out_cos_tol", int'(out_cos), ref_real(int'(e.k), 1'b0));
                        chk_tol("out_sin_tol", int'(out_sin), ref_real(int'(e.k), 1'b1));
                    end
                    if (e.chk_lat) chk("latency", longint'(cyc - e.acc_cyc), 2);
                end
                if (mon_pops == 0) first_pop = cyc;
                last_pop = cyc;
                mon_pops++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic obs();
        @(negedge clk); #1;
    endtask

    task automatic drain(input string name, input int limit);
        bit done;
        done = 0;
        for (int t = 0; t < limit; t++) begin
            obs();
            if (sb.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) chk({name, "_drain_timeout"}, 0, 1);
    endtask

    task automatic push_sweep(input int stride, input int count);
        exp_t e;
        int   k;
        k = 0;
        for (int i = 0; i < count; i++) begin
            e.k       = 4'(k);
            e.cosv    = ref_round(k, 1'b0);
            e.sinv    = ref_round(k, 1'b1);
            e.last    = (i == count - 1);
            e.exact   = 1;
            e.chk_lat = 0;
            e.acc_cyc = 0;
            sb.push_back(e);
            k = (k + stride) % 16;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok, acc, seen;
        int bsy;

        vt[0] = '{k: 4'd0, c:  32767, s:     0};
        vt[1] = '{k: 4'd4, c:      0, s: 32767};
        vt[2] = '{k: 4'd8, c: -32767, s:     0};
        vt[3] = '{k: 4'd2, c:  23170, s: 23170};
        vt[4] = '{k: 4'd5, c: -12540, s: 30274};

        rst_n = 0; req_valid = 0; req_k = 0; sweep_start = 0;
        sweep_stride = 0; sweep_count = 0; out_ready = 1;
        nxt_c = 0; nxt_s = 0;

        // reset state
        repeat (2) @(posedge clk);
        obs();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_cos", longint'(out_cos), 0);
        chk("rst_out_sin", longint'(out_sin), 0);
        chk("rst_out_k", longint'(out_k), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_sweep_busy", longint'(sweep_busy), 0);
        step();
        rst_n = 1;
        obs();
        chk("idle_req_ready", longint'(req_ready), 1);

        // 1. single lookups from the vector table, 2-cycle latency
        for (int i = 0; i < 5; i++) begin
            step();
            nxt_c = vt[i].c; nxt_s = vt[i].s; mode_tol = 0; mode_lat = 1;
            req_valid = 1; req_k = vt[i].k;
            acc = 0;
            for (int t = 0; t < 10; t++) begin
                obs();
                if (req_ready) begin acc = 1; break; end
                step();
            end
            if (!acc) chk("single_accept_timeout", 0, 1);
            step();
            req_valid = 0;
            drain("single", 20);
        end
        mode_lat = 0;

        // 2. exhaustive back-to-back lookups
        step();
        mode_tol = 1; mon_pops = 0; ok = 1;
        req_valid = 1;
        for (int kk = 0; kk < 16; kk++) begin
            req_k = 4'(kk);
            obs();
            if (!req_ready) ok = 0;
            step();
        end
        req_valid = 0;
        drain("exhaustive", 30);
        mode_tol = 0;
        chk("exh_ready_each_cycle", longint'(ok), 1);
        chk("exh_word_count", mon_pops, 16);
        chk("exh_one_per_cycle", last_pop - first_pop, 15);

        // 3. sweep stride 3 count 6, requests held off throughout
        step();
        push_sweep(3, 6);
        sweep_start = 1; sweep_stride = 3; sweep_count = 6;
        step();
        sweep_start = 0; req_valid = 1; req_k = 7;
        nxt_c = 99999; nxt_s = 99999;
        obs();
        chk("sweep_busy_rise", longint'(sweep_busy), 1);
        ok = 1; seen = 0; bsy = 0;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) obs();
            if (req_ready) ok = 0;
            if (out_valid && out_ready && out_last) begin
                seen = 1; bsy = int'(sweep_busy);
                break;
            end
        end
        req_valid = 0;
        chk("sweep_last_seen", longint'(seen), 1);
        chk("sweep_busy_at_last", bsy, 1);
        chk("sweep_req_ready_low", longint'(ok), 1);
        obs();
        chk("sweep_busy_fall", longint'(sweep_busy), 0);
        drain("sweep3", 20);

        // 4. backpressure for 3 cycles mid-sweep
        step();
        push_sweep(1, 8);
        sweep_start = 1; sweep_stride = 1; sweep_count = 8;
        step();
        sweep_start = 0;
        repeat (3) step();
        out_ready = 0;
        for (int j = 0; j < 3; j++) begin
            obs();
            chk("stall_valid", longint'(out_valid), 1);
            if (sb.size() > 0) begin
                chk("stall_k", longint'(out_k), longint'(sb[0].k));
                chk("stall_cos", longint'(out_cos), longint'(sb[0].cosv));
                chk("stall_sin", longint'(out_sin), longint'(sb[0].sinv));
            end else begin
                chk("stall_sb_empty", 0, 1);
            end
            step();
        end
        out_ready = 1;
        drain("backpressure", 40);

        // 5a. request and sweep_start together: sweep wins
        step();
        push_sweep(2, 3);
        nxt_c = 99999; nxt_s = 99999;
        req_valid = 1; req_k = 5;
        sweep_start = 1; sweep_stride = 2; sweep_count = 3;
        obs();
        chk("arb_req_ready", longint'(req_ready), 0);
        step();
        req_valid = 0; sweep_start = 0;
        drain("arb", 40);
        chk("arb_busy_after", longint'(sweep_busy), 0);

        // 5b. sweep_start with count 0 is ignored
        step();
        sweep_start = 1; sweep_stride = 1; sweep_count = 0;
        step();
        sweep_start = 0;
        ok = 1;
        for (int t = 0; t < 8; t++) begin
            obs();
            if (sweep_busy || out_valid) ok = 0;
            step();
        end
        chk("zero_count_ignored", longint'(ok), 1);

        // 6. reset during a sweep with the third word pending
        push_sweep(1, 8);
        sweep_start = 1; sweep_stride = 1; sweep_count = 8;
        mon_pops = 0;
        step();
        sweep_start = 0;
        seen = 0;
        for (int t = 0; t < 30; t++) begin
            obs();
            if (mon_pops >= 2) begin seen = 1; break; end
        end
        chk("reset_two_words_seen", longint'(seen), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_out_cos", longint'(out_cos), 0);
        chk("mid_rst_out_sin", longint'(out_sin), 0);
        chk("mid_rst_out_k", longint'(out_k), 0);
        chk("mid_rst_out_last", longint'(out_last), 0);
        chk("mid_rst_busy", longint'(sweep_busy), 0);
        sb.delete();
        step();
        rst_n = 1;
        ok = 1;
        for (int t = 0; t < 10; t++) begin
            obs();
            if (out_valid || sweep_busy) ok = 0;
            step();
        end
        chk("post_rst_quiet", longint'(ok), 1);
        obs();
        chk("post_rst_req_ready", longint'(req_ready), 1);

        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
